// File: rtl/mips_mdu_pkg.sv
// rtl/mips_mdu_pkg.sv - shared types and helpers for the MIPS multiply/divide unit
//
// Holds the op encoding seen on mips_mdu.op, the FSM state encoding and the
// iteration-counter width helper, so that every file of the unit agrees on them.
package mips_mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    // The counter has to hold DATA_WIDTH itself, not just DATA_WIDTH-1.
    function automatic int mdu_cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/mips_mdu_signfix.sv
// rtl/mips_mdu_signfix.sv - conditional two's-complement negation
//
// Used both to take operand magnitudes (negate = signed op and sign bit set)
// and to apply the final result sign.
// Ports:
//   value  [WIDTH-1:0]  input operand
//   negate              1 = output -value, 0 = output value
//   result [WIDTH-1:0]  output
module mips_mdu_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/mips_mdu.sv
// rtl/mips_mdu.sv - iterative MIPS HI/LO multiply/divide unit
//
// Radix-2 shift-add multiply and restoring divide, one bit per clock, with
// MTHI/MTLO write ports and pipeline flush.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, op[1:0]      launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   a, b                rs/rt operands (dividend/divisor for divide)
//   flush               cancel an in-flight operation, HI/LO untouched
//   hi_we, lo_we, wdata MTHI/MTLO writes (ignored while busy)
//   busy                high while not IDLE
//   done                one-cycle pulse when an operation wrote HI/LO
//   hi, lo              architectural HI/LO registers
// Build option: define MIPS_MDU_EARLY_OUT_EN to end multiply iteration once the
// remaining multiplier bits are all zero.
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = mdu_cnt_width(DATA_WIDTH);

    mdu_state_e     state;
    logic           fix_phase;   // FIX: 0 = sign-correct in place, 1 = commit to HI/LO
    logic [CW-1:0]  cnt;         // iterations still owed (also the final multiply shift)
    logic           is_div;
    logic           neg_res;     // negate product / quotient
    logic           neg_rem;     // negate remainder
    logic [W-1:0]   acc;         // product high half / partial remainder
    logic [W-1:0]   rq;          // multiplier then product low half / dividend then quotient
    logic [W-1:0]   dsr;         // multiplicand / divisor magnitude

    mdu_op_e        op_e;
    logic           op_signed;
    logic           op_div;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;

    logic [W:0]     mul_sum;
    logic [W:0]     div_trial;
    logic [W-1:0]   step_acc;
    logic [W-1:0]   step_rq;
    logic           last_step;
`ifdef MIPS_MDU_EARLY_OUT_EN
    logic [W-1:0]   low_mask;
`endif

    logic [2*W-1:0] shifted;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    assign op_e      = mdu_op_e'(op);
    assign op_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign op_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
    assign busy      = (state != S_IDLE);

    mips_mdu_signfix #(.WIDTH(W)) u_abs_a (
        .value (a),
        .negate(op_signed & a[W-1]),
        .result(a_mag)
    );

    mips_mdu_signfix #(.WIDTH(W)) u_abs_b (
        .value (b),
        .negate(op_signed & b[W-1]),
        .result(b_mag)
    );

    always_comb begin
        mul_sum   = {1'b0, acc} + (rq[0] ? {1'b0, dsr} : {(W+1){1'b0}});
        div_trial = {acc, rq[W-1]} - {1'b0, dsr};
        if (is_div) begin
            if (!div_trial[W]) begin
                step_acc = div_trial[W-1:0];
                step_rq  = {rq[W-2:0], 1'b1};
            end else begin
                step_acc = {acc[W-2:0], rq[W-1]};
                step_rq  = {rq[W-2:0], 1'b0};
            end
        end else begin
            // Product bits enter rq from the top as multiplier bits leave the bottom.
            step_acc = mul_sum[W:1];
            step_rq  = {mul_sum[0], rq[W-1:1]};
        end
        last_step = (cnt == CW'(1));
`ifdef MIPS_MDU_EARLY_OUT_EN
        // After this step the unconsumed multiplier bits are the low cnt-1 bits of rq.
        for (int i = 0; i < W; i++) begin
            low_mask[i] = (i + 1 < int'(cnt));
        end
        if (!is_div && ((step_rq & low_mask) == '0)) begin
            last_step = 1'b1;
        end
`endif
    end

    // Skipped multiply iterations would only shift right; cnt is zero otherwise.
    assign shifted = {acc, rq} >> cnt;

    mips_mdu_signfix #(.WIDTH(2*W)) u_fix_prod (
        .value (shifted),
        .negate(neg_res),
        .result(prod_fix)
    );

    mips_mdu_signfix #(.WIDTH(W)) u_fix_quo (
        .value (rq),
        .negate(neg_res),
        .result(quo_fix)
    );

    mips_mdu_signfix #(.WIDTH(W)) u_fix_rem (
        .value (acc),
        .negate(neg_rem),
        .result(rem_fix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            fix_phase <= 1'b0;
            cnt       <= '0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            acc       <= '0;
            rq        <= '0;
            dsr       <= '0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        is_div    <= op_div;
                        dsr       <= b_mag;
                        fix_phase <= 1'b0;
                        if (op_div && (b == '0)) begin
                            // Divide by zero: park the final answer and go straight to FIX.
                            acc     <= a;
                            rq      <= '1;
                            cnt     <= '0;
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= S_FIX;
                        end else begin
                            acc     <= '0;
                            rq      <= a_mag;
                            cnt     <= CW'(W);
                            neg_res <= op_signed & (a[W-1] ^ b[W-1]);
                            neg_rem <= op_signed & op_div & a[W-1];
                            state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= step_acc;
                        rq  <= step_rq;
                        cnt <= cnt - CW'(1);
                        if (last_step) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (!fix_phase) begin
                        fix_phase <= 1'b1;
                        cnt       <= '0;
                        if (is_div) begin
                            acc <= rem_fix;
                            rq  <= quo_fix;
                        end else begin
                            {acc, rq} <= prod_fix;
                        end
                    end else begin
                        hi    <= acc;
                        lo    <= rq;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mdu.sv
// tb/tb_mips_mdu.sv - self-checking bench for mips_mdu (DATA_WIDTH = 32)
module tb_mips_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_bad;

    mips_mdu #(.DATA_WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .flush(flush),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic on the operands.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: p = 64'(sx * sy);
            2'b01: p = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    if (o == 2'b11) begin
                        sx = longint'({32'd0, x});
                        sy = longint'({32'd0, y});
                    end
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Number of edges from the accepting edge to the one after which done is seen.
    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int run_cycles;
        logic [31:0] m;
        run_cycles = 32;
        if (o[1] && (y == 32'd0)) return 2;
`ifdef MIPS_MDU_EARLY_OUT_EN
        if (!o[1]) begin
            m = (o == 2'b00 && x[31]) ? (32'd0 - x) : x;
            run_cycles = 1;
            for (int i = 0; i < 32; i++) begin
                if (m[i]) run_cycles = i + 1;
            end
        end
`else
        m = x;
        if (m == 32'd0) run_cycles = 32;
`endif
        return run_cycles + 2;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done after a launch; lat = edges counted from the accepting edge, -1 on timeout.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = busy;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] exp;
        int          lat;
        bit          busy_ok;
        exp = ref_result(o, x, y);
        launch(o, x, y);
        wait_done(lat, busy_ok);
        check({tag, ".latency"}, lat, ref_latency(o, x, y));
        check({tag, ".busy_during"}, busy_ok, 1);
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".hi"}, hi, exp[63:32]);
        check({tag, ".lo"}, lo, exp[31:0]);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, done, 0);
    endtask

    initial begin
        int          lat;
        bit          busy_ok;
        bit          done_seen;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int          sel;
        logic [63:0] exp;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #23;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.hi", hi, 0);
        check("reset.lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors.
        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op("divu_zero", 2'b11, 32'd5, 32'd0);
        do_op("div_zero_s", 2'b10, 32'hFFFF_FFFB, 32'd0);
        do_op("div_minneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("multu_small", 2'b01, 32'd3, 32'd1);
        do_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        do_op("mult_zero", 2'b00, 32'd0, 32'hFFFF_FFFF);

        // MTHI/MTLO, then flush at RUN cycle 10.
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h22;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush.busy", busy, 0);
        check("flush.hi", hi, 32'h11);
        check("flush.lo", lo, 32'h22);
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check("flush.no_done", done_seen, 0);

        // start together with flush in IDLE does not launch.
        @(negedge clk);
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("start_flush.busy", busy, 0);

        // MTHI in IDLE with start: write lands and op is accepted.
        @(negedge clk);
        op    = 2'b01;
        a     = 32'd2;
        b     = 32'd3;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'h5A5A;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        check("mt_start.hi", hi, 32'h5A5A);
        check("mt_start.busy", busy, 1);
        wait_done(lat, busy_ok);
        check("mt_start.lo", lo, 32'd6);
        check("mt_start.hi_final", hi, 32'd0);

        // MTHI while busy is ignored.
        launch(2'b00, 32'hFFFF_FF00, 32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hABCD;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("mthi_busy.immediate", hi, 32'd0);
        wait_done(lat, busy_ok);
        exp = ref_result(2'b00, 32'hFFFF_FF00, 32'd5);
        check("mthi_busy.hi", hi, exp[63:32]);
        check("mthi_busy.lo", lo, exp[31:0]);

        // Asynchronous reset mid-RUN.
        launch(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset.busy", busy, 0);
        check("areset.done", done, 0);
        check("areset.hi", hi, 0);
        check("areset.lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op("after_reset", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            o   = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            x   = $urandom;
            y   = $urandom;
            case (sel)
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: x = 32'($urandom_range(0, 255));
                3: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op("rand", o, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mdu.md
MIPS_MDU -- requirements
Module: mips_mdu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  launch operation (sampled in IDLE only).
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a, b  input  DATA_WIDTH  rs/rt operands (dividend/divisor for div).
REQ-007 SHALL have port flush  input  1  cancel in-flight operation (pipeline flush).
REQ-008 SHALL have ports hi_we, lo_we  input  1  MTHI/MTLO write strobes.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  MTHI/MTLO data.
REQ-010 SHALL have port busy  output  1  high while not IDLE; pipeline stalls MFHI/MFLO/new ops on it.
REQ-011 SHALL have port done  output  1  one-cycle pulse when HI/LO updated by an operation.
REQ-012 SHALL have ports hi, lo  output  DATA_WIDTH  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FIX -> IDLE; start in IDLE enters RUN, else stays IDLE.
REQ-014 SHALL latch |a|, |b| (signed ops) or a, b (unsigned ops) and the result signs on the accepting edge.
REQ-015 SHALL iterate radix-2 in RUN, one bit per cycle, exactly DATA_WIDTH cycles (shift-add multiply, restoring divide).
REQ-016 SHALL apply sign correction in FIX (negate product if signs differ; quotient negated if signs differ, remainder takes dividend sign).
REQ-017 SHALL write HI/LO and pulse done on the edge leaving FIX: start at edge 0 -> done/HI/LO valid after edge DATA_WIDTH+2.
REQ-018 SHALL produce multiply result HI:LO = full 2*DATA_WIDTH product; divide LO = quotient, HI = remainder.
REQ-019 SHALL handle divide by zero without iterating: IDLE -> FIX, HI = a, LO = all ones, done after edge 2.
REQ-020 SHALL give DIV of most-negative by -1 as LO = most-negative, HI = 0 (modular wrap, no trap).
REQ-021 SHALL ignore start, hi_we, lo_we while busy.
REQ-022 SHALL, in IDLE with hi_we/lo_we and start together, apply the write on that edge and also accept start.
REQ-023 SHALL, on flush in RUN or FIX, return to IDLE next edge, leave HI/LO unchanged, no done; flush with start in IDLE wins (no launch).

Reset
REQ-024 SHALL, on reset asserted at any time including mid-operation, force IDLE, busy=0, done=0, hi=0, lo=0 immediately.
REQ-025 SHALL resume normal operation on the first rising clk after reset deasserts.

Configuration
REQ-026 SHALL, with MIPS_MDU_EARLY_OUT_EN defined, leave RUN for multiply as soon as remaining multiplier bits are all zero (minimum 1 RUN cycle), shifting the partial product into place in FIX.
REQ-027 SHALL, without MIPS_MDU_EARLY_OUT_EN, use fixed latency DATA_WIDTH+2 for all non-zero-divisor operations; divide latency SHALL be fixed in both builds.

Structure
REQ-028 SHALL take op encodings, FSM state enum and iteration-counter width ($clog2(DATA_WIDTH+1)) from shared package mips_mdu_pkg.
REQ-029 SHALL place absolute value and final negation in one combinational sub-module mips_mdu_signfix, instantiated for operand and result paths.

Verification (DATA_WIDTH=32, macro undefined unless stated)
REQ-030 SHALL check MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done after edge 34, busy high for edges 1-34.
REQ-031 SHALL check MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 SHALL check DIVU a=5 b=0 -> hi=0x00000005, lo=0xFFFFFFFF, done after edge 2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-033 SHALL check flush at RUN cycle 10 with prior hi=0x11, lo=0x22 -> IDLE next edge, hi/lo unchanged, no done; start+flush together -> no launch.
REQ-034 SHALL check reset asserted mid-RUN -> busy, done, hi, lo all 0 without a clock edge; MTHI 0xABCD while busy ignored.
REQ-035 SHALL check with MIPS_MDU_EARLY_OUT_EN: MULTU 3*1 -> lo=3, hi=0, done well before edge 34; DIVU 100/7 -> lo=14, hi=2 after edge 34.
